// File: rtl/sterownik_jasnosci_pkg.sv
// Shared types and constants for the LED brightness controller.
package sterownik_jasnosci_pkg;

    typedef enum logic [1:0] {
        BEZCZYNNY = 2'd0,
        CZEKAJ    = 2'd1,
        POWTARZAJ = 2'd2
    } stan_powt_t;

    localparam logic [1:0] POZIOM_MIN = 2'd0;
    localparam logic [1:0] POZIOM_MAX = 2'd3;

    function automatic int wiekszy(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sterownik_jasnosci_przycisk_filtr.sv
// One push-button channel: two-flop synchroniser, debounce and auto-repeat,
// producing a registered one-cycle event pulse.
//
// state     | meaning
// BEZCZYNNY | button released, waiting for a debounced press
// CZEKAJ    | first event sent, counting down the initial repeat delay
// POWTARZAJ | button still held, emitting an event every repeat period
module przycisk_filtr
    import sterownik_jasnosci_pkg::*;
#(
    parameter int CZAS_DREBOW     = 100000,
    parameter int OPOZNIENIE_POWT = 5000000,
    parameter int OKRES_POWT      = 2000000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_przycisk,
    output logic o_zdarzenie
);

    localparam int DREB_W = $clog2(CZAS_DREBOW + 1);
    localparam int POWT_W = $clog2(wiekszy(OPOZNIENIE_POWT, OKRES_POWT) + 1);
    localparam logic [DREB_W-1:0] DREB_KONIEC = DREB_W'(CZAS_DREBOW - 1);
    localparam logic [POWT_W-1:0] OPOZ_LAD    = POWT_W'(OPOZNIENIE_POWT - 1);
    localparam logic [POWT_W-1:0] OKRES_LAD   = POWT_W'(OKRES_POWT - 1);

    logic              r_sync1;
    logic              r_sync2;
    logic              r_stabilny;
    logic [DREB_W-1:0] r_licz_drgan;

    stan_powt_t        r_stan;
    logic [POWT_W-1:0] r_licz_powt;
    logic              r_zdarzenie;

    stan_powt_t        w_stan_nast;
    logic [POWT_W-1:0] w_licz_nast;
    logic              w_zdarzenie_nast;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1      <= 1'b0;
            r_sync2      <= 1'b0;
            r_stabilny   <= 1'b0;
            r_licz_drgan <= '0;
        end else begin
            r_sync1 <= i_przycisk;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_stabilny) begin
                r_licz_drgan <= '0;
            end else if (r_licz_drgan == DREB_KONIEC) begin
                r_stabilny   <= ~r_stabilny;
                r_licz_drgan <= '0;
            end else begin
                r_licz_drgan <= r_licz_drgan + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stan      <= BEZCZYNNY;
            r_licz_powt <= '0;
            r_zdarzenie <= 1'b0;
        end else begin
            r_stan      <= w_stan_nast;
            r_licz_powt <= w_licz_nast;
            r_zdarzenie <= w_zdarzenie_nast;
        end
    end

    // Stable can only be high while idle right after a debounced rising edge,
    // since the busy states return to idle only once it has dropped.
    always_comb begin
        w_stan_nast      = r_stan;
        w_licz_nast      = r_licz_powt;
        w_zdarzenie_nast = 1'b0;
        case (r_stan)
            BEZCZYNNY: begin
                if (r_stabilny) begin
                    w_zdarzenie_nast = 1'b1;
                    w_licz_nast      = OPOZ_LAD;
                    w_stan_nast      = CZEKAJ;
                end
            end
            CZEKAJ: begin
                if (!r_stabilny) begin
                    w_stan_nast = BEZCZYNNY;
                    w_licz_nast = '0;
                end else if (r_licz_powt == '0) begin
                    w_zdarzenie_nast = 1'b1;
                    w_licz_nast      = OKRES_LAD;
                    w_stan_nast      = POWTARZAJ;
                end else begin
                    w_licz_nast = r_licz_powt - 1'b1;
                end
            end
            POWTARZAJ: begin
                if (!r_stabilny) begin
                    w_stan_nast = BEZCZYNNY;
                    w_licz_nast = '0;
                end else if (r_licz_powt == '0) begin
                    w_zdarzenie_nast = 1'b1;
                    w_licz_nast      = OKRES_LAD;
                end else begin
                    w_licz_nast = r_licz_powt - 1'b1;
                end
            end
            default: begin
                w_stan_nast = BEZCZYNNY;
                w_licz_nast = '0;
            end
        endcase
    end

    assign o_zdarzenie = r_zdarzenie;

endmodule

// File: rtl/sterownik_jasnosci.sv
// LED brightness controller: up/down button channels stepping a saturating
// 2-bit level that selects the PWM duty.
module sterownik_jasnosci
    import sterownik_jasnosci_pkg::*;
#(
    parameter int         CZAS_DREBOW     = 100000,
    parameter int         OPOZNIENIE_POWT = 5000000,
    parameter int         OKRES_POWT      = 2000000,
    parameter logic [1:0] POZIOM_START    = 2'b00
) (
    input  logic       in_clk,
    input  logic       in_rst_n,
    input  logic       in_przycisk_gora,
    input  logic       in_przycisk_dol,
    output logic [1:0] out_poziom,
    output logic       out_przycisk1,
    output logic       out_przycisk2,
    output logic       out_zmiana
);

    logic       w_zdarz_gora;
    logic       w_zdarz_dol;
    logic [1:0] r_poziom;
    logic       r_zmiana;

    przycisk_filtr #(
        .CZAS_DREBOW     (CZAS_DREBOW),
        .OPOZNIENIE_POWT (OPOZNIENIE_POWT),
        .OKRES_POWT      (OKRES_POWT)
    ) u_gora (
        .i_clk       (in_clk),
        .i_rst_n     (in_rst_n),
        .i_przycisk  (in_przycisk_gora),
        .o_zdarzenie (w_zdarz_gora)
    );

    przycisk_filtr #(
        .CZAS_DREBOW     (CZAS_DREBOW),
        .OPOZNIENIE_POWT (OPOZNIENIE_POWT),
        .OKRES_POWT      (OKRES_POWT)
    ) u_dol (
        .i_clk       (in_clk),
        .i_rst_n     (in_rst_n),
        .i_przycisk  (in_przycisk_dol),
        .o_zdarzenie (w_zdarz_dol)
    );

    // Simultaneous up and down events cancel each other.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_poziom <= POZIOM_START;
            r_zmiana <= 1'b0;
        end else begin
            r_zmiana <= 1'b0;
            if (w_zdarz_gora && !w_zdarz_dol && (r_poziom != POZIOM_MAX)) begin
                r_poziom <= r_poziom + 2'd1;
                r_zmiana <= 1'b1;
            end else if (w_zdarz_dol && !w_zdarz_gora && (r_poziom != POZIOM_MIN)) begin
                r_poziom <= r_poziom - 2'd1;
                r_zmiana <= 1'b1;
            end
        end
    end

    assign out_poziom    = r_poziom;
    assign out_przycisk1 = r_poziom[1];
    assign out_przycisk2 = r_poziom[0];
    assign out_zmiana    = r_zmiana;

endmodule

// File: tb/tb_sterownik_jasnosci.sv
// Scoreboard bench for sterownik_jasnosci: each press queues the level it
// should produce and the cycle it should appear in.
module tb_sterownik_jasnosci;

    localparam int CZAS  = 4;
    localparam int OPOZ  = 20;
    localparam int OKRES = 8;
    // Input driven at a falling edge -> level visible at the falling edge
    // CZAS+4 rising edges later (CZAS+3 edges after the first sampling edge).
    localparam int LAT   = CZAS + 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       gora  = 1'b0;
    logic       dol   = 1'b0;
    logic [1:0] poziom;
    logic       p1;
    logic       p2;
    logic       zmiana;

    int checks  = 0;
    int errors  = 0;
    int cyc     = 0;
    int n_zmian = 0;

    typedef struct {
        int poziom;
        int cykl;
    } oczek_t;
    oczek_t kolejka[$];

    sterownik_jasnosci #(
        .CZAS_DREBOW     (CZAS),
        .OPOZNIENIE_POWT (OPOZ),
        .OKRES_POWT      (OKRES),
        .POZIOM_START    (2'b00)
    ) dut (
        .in_clk           (clk),
        .in_rst_n         (rst_n),
        .in_przycisk_gora (gora),
        .in_przycisk_dol  (dol),
        .out_poziom       (poziom),
        .out_przycisk1    (p1),
        .out_przycisk2    (p2),
        .out_zmiana       (zmiana)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic sprawdz(input string tag, input logic [31:0] obs, input logic [31:0] ocz);
        checks++;
        if (obs !== ocz) begin
            errors++;
            $display("FAIL %s: jest %0d, oczekiwano %0d", tag, obs, ocz);
        end
    endtask

    task automatic cykle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic oczekuj(input int p, input int c);
        oczek_t e;
        e.poziom = p;
        e.cykl   = c;
        kolejka.push_back(e);
    endtask

    task automatic sprawdz_wyjscia(input string tag, input logic [1:0] ocz);
        sprawdz({tag, "_poziom"}, poziom, ocz);
        sprawdz({tag, "_przycisk1"}, p1, ocz[1]);
        sprawdz({tag, "_przycisk2"}, p2, ocz[0]);
    endtask

    task automatic zresetuj();
        @(negedge clk);
        gora  = 1'b0;
        dol   = 1'b0;
        rst_n = 1'b0;
        cykle(3);
        kolejka.delete();
        rst_n = 1'b1;
    endtask

    initial begin
        int n0;
        int t;

        fork
            forever begin
                oczek_t e;
                @(negedge clk);
                if (rst_n && zmiana) begin
                    n_zmian++;
                    if (kolejka.size() == 0) begin
                        sprawdz("zmiana_nieoczekiwana", 1, 0);
                    end else begin
                        e = kolejka.pop_front();
                        sprawdz("poziom_po_zmianie", poziom, e.poziom);
                        sprawdz("cykl_zmiany", cyc, e.cykl);
                    end
                end
            end
        join_none

        // 1: reset values, then idle
        #1;
        sprawdz_wyjscia("s1_reset", 2'd0);
        sprawdz("s1_reset_zmiana", zmiana, 0);
        cykle(3);
        rst_n = 1'b1;
        n0 = n_zmian;
        cykle(100);
        sprawdz_wyjscia("s1_bezczynny", 2'd0);
        sprawdz("s1_zmiany", n_zmian - n0, 0);

        // 2: clean up press, 10 cycles
        n0 = n_zmian;
        gora = 1'b1;
        oczekuj(1, cyc + LAT);
        cykle(10);
        gora = 1'b0;
        cykle(30);
        sprawdz_wyjscia("s2", 2'd1);
        sprawdz("s2_zmiany", n_zmian - n0, 1);
        sprawdz("s2_kolejka", kolejka.size(), 0);

        // 3: bouncing press never settles
        zresetuj();
        n0 = n_zmian;
        repeat (5) begin
            gora = 1'b1;
            cykle(3);
            gora = 1'b0;
            cykle(1);
        end
        cykle(30);
        sprawdz_wyjscia("s3", 2'd0);
        sprawdz("s3_zmiany", n_zmian - n0, 0);

        // 4: long hold with auto-repeat and saturation at 3
        n0 = n_zmian;
        gora = 1'b1;
        t = cyc;
        oczekuj(1, t + LAT);
        oczekuj(2, t + LAT + OPOZ);
        oczekuj(3, t + LAT + OPOZ + OKRES);
        cykle(60);
        gora = 1'b0;
        cykle(30);
        sprawdz_wyjscia("s4", 2'd3);
        sprawdz("s4_zmiany", n_zmian - n0, 3);
        sprawdz("s4_kolejka", kolejka.size(), 0);

        // 5: simultaneous presses cancel; down saturates at 0
        zresetuj();
        gora = 1'b1;
        oczekuj(1, cyc + LAT);
        cykle(10);
        gora = 1'b0;
        cykle(20);
        sprawdz_wyjscia("s5_start", 2'd1);
        n0 = n_zmian;
        gora = 1'b1;
        dol  = 1'b1;
        cykle(10);
        gora = 1'b0;
        dol  = 1'b0;
        cykle(20);
        sprawdz_wyjscia("s5_oba", 2'd1);
        sprawdz("s5_oba_zmiany", n_zmian - n0, 0);
        n0 = n_zmian;
        dol = 1'b1;
        oczekuj(0, cyc + LAT);
        cykle(10);
        dol = 1'b0;
        cykle(20);
        dol = 1'b1;
        cykle(10);
        dol = 1'b0;
        cykle(20);
        sprawdz_wyjscia("s5_dol", 2'd0);
        sprawdz("s5_dol_zmiany", n_zmian - n0, 1);
        sprawdz("s5_kolejka", kolejka.size(), 0);

        // 6: asynchronous reset during a hold, button still held afterwards
        zresetuj();
        gora = 1'b1;
        t = cyc;
        oczekuj(1, t + LAT);
        oczekuj(2, t + LAT + OPOZ);
        cykle(30);
        sprawdz_wyjscia("s6_przed", 2'd2);
        sprawdz("s6_kolejka_przed", kolejka.size(), 0);
        #3;
        rst_n = 1'b0;
        #1;
        sprawdz_wyjscia("s6_async", 2'd0);
        sprawdz("s6_async_zmiana", zmiana, 0);
        kolejka.delete();
        @(negedge clk);
        cykle(2);
        rst_n = 1'b1;
        n0 = n_zmian;
        oczekuj(1, cyc + LAT);
        cykle(12);
        gora = 1'b0;
        cykle(20);
        sprawdz_wyjscia("s6_po", 2'd1);
        sprawdz("s6_zmiany", n_zmian - n0, 1);
        sprawdz("s6_kolejka", kolejka.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sterownik_jasnosci.md
# sterownik_jasnosci

Upstream control stage for the PWM LED brightness block: turns two raw push-buttons (up/down) into the 2-bit brightness level that drives the PWM block's `in_przycisk1`/`in_przycisk2` select inputs. Each button is synchronised, debounced and auto-repeated while held. Button events step a saturating level register between 0 (10 % duty) and 3 (100 % duty).

## Interface
- `CZAS_DREBOW`, 100000: consecutive stable cycles needed to accept a new button state (10 ms at 10 MHz); must be ≥1.
- `OPOZNIENIE_POWT`, 5000000: hold cycles from the first event to the first auto-repeat event (0.5 s); must be ≥1.
- `OKRES_POWT`, 2000000: cycles between subsequent auto-repeat events (0.2 s); must be ≥1.
- `POZIOM_START`, 2'b00: level loaded at reset.

Ports:
- `in_clk` input 1: system clock, 10 MHz.
- `in_rst_n` input 1: reset, asynchronous, active-low.
- `in_przycisk_gora` input 1: raw "up" button, active-high, asynchronous to `in_clk`, bouncy.
- `in_przycisk_dol` input 1: raw "down" button, same properties.
- `out_poziom` output 2: current level.
- `out_przycisk1` output 1: equals `out_poziom[1]`; connects to the PWM block's `in_przycisk1`.
- `out_przycisk2` output 1: equals `out_poziom[0]`; connects to the PWM block's `in_przycisk2`.
- `out_zmiana` output 1: one-cycle pulse when the level actually changed.

## Operation
- Per button: two-flop synchroniser (reset 0) feeding debounce logic.
  - Debounce keeps a stable value (reset 0) and a counter (reset 0).
  - Synchroniser output equal to stable: the counter clears.
  - Otherwise the counter increments. On the `CZAS_DREBOW`-th consecutive differing edge, stable flips and the counter clears.
- Per button: auto-repeat FSM, states BEZCZYNNY, CZEKAJ, POWTARZAJ (reset BEZCZYNNY).
  - BEZCZYNNY: on a stable 0→1 transition, emit one event, load the repeat counter, go to CZEKAJ.
  - CZEKAJ: stable 0 → BEZCZYNNY, no event. After `OPOZNIENIE_POWT` cycles in the state, emit an event and go to POWTARZAJ.
  - POWTARZAJ: stable 0 → BEZCZYNNY. Otherwise emit an event every `OKRES_POWT` cycles.
  - Events are registered one-cycle pulses.
- Level register (reset `POZIOM_START`):
  - Up event only: +1, saturating at 3.
  - Down event only: −1, saturating at 0.
  - Both in the same cycle: no change.
- `out_zmiana` (reset 0) is high for exactly the cycle after a level change. It is not asserted for saturated or cancelled events.
- Counter widths are `$clog2(param+1)`. Counters never wrap, because they are cleared or reloaded on terminal count.
- Reset mid-operation: all state returns to its reset value immediately. A button still held after reset release is treated as a new press.

## Timing
- Raw input changes and is held from before edge k:
  - Synchroniser output reflects the change after edge k+1.
  - Stable value flips after edge k+1+`CZAS_DREBOW`.
  - Event pulse is high after edge k+2+`CZAS_DREBOW`.
  - `out_poziom` and `out_zmiana` update after edge k+3+`CZAS_DREBOW`.
- Total press-to-level latency is `CZAS_DREBOW`+3 edges.
- Auto-repeat events fall `OPOZNIENIE_POWT` cycles after the first event, then every `OKRES_POWT` cycles.
- Glitches shorter than `CZAS_DREBOW` cycles at the synchroniser output produce no event.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Reset values: `out_poziom` = `POZIOM_START`; `out_przycisk1`/`out_przycisk2` derived from it; `out_zmiana` = 0.

## Structure
- Package `sterownik_jasnosci_pkg` holds:
  - the FSM state enum typedef (BEZCZYNNY, CZEKAJ, POWTARZAJ);
  - the level constants `POZIOM_MIN` = 0 and `POZIOM_MAX` = 3.
- Sub-module `przycisk_filtr` contains synchroniser + debounce + auto-repeat FSM and outputs an event pulse. It is instantiated twice. The top level holds only the level register and `out_zmiana`.

## Test plan
Parameters for all scenarios: `CZAS_DREBOW`=4, `OPOZNIENIE_POWT`=20, `OKRES_POWT`=8.

1. Reset, buttons low → `out_poziom`=0, `out_przycisk1`=`out_przycisk2`=0, `out_zmiana`=0; unchanged for 100 cycles.
2. Clean up press held 10 cycles, from level 0 → level 1 exactly 7 edges after the first sampling edge; one `out_zmiana` pulse.
3. Bouncing up press (high 3 cycles, low 1, repeated 5×, then low) → level stays 0, no `out_zmiana`.
4. Up held 60 cycles from level 0 → events at t, t+20, t+28, t+36; level goes 1, 2, 3, then stays at 3; exactly 3 `out_zmiana` pulses.
5. Up and down pressed on the same cycle at level 1 → level stays 1, no `out_zmiana`; down alone then steps to 0 and saturates there.
6. `in_rst_n` pulsed low mid-hold at level 2 → outputs go to reset values without waiting for a clock edge; the held button then yields level 1 `CZAS_DREBOW`+3 edges after reset release.
